// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Retires one instruction per cycle
// into the register file, extends/lane-selects LOAD data, expands LOADI
// immediates, waits on mem_valid (stalling upstream), times out a hung bus
// and halts via a sticky flag.
// Encodings: opcode NOP=0, LOAD=1, LOADI=2. LOAD width CW_BYTE=0, CW_WORD=1,
// CW_LONG=2 (low 32 bits), CW_FULL=3 (whole DATA_WIDTH word). LOADI type
// IT_UNSIGNED=0, IT_SIGNED=1, IT_TOP=2, IT_BOTTOM=3.
// While waiting on memory the stage ignores the inbound port; upstream keeps
// the next instruction parked there until stall drops.
module writeback_stage #(
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_WAIT   = 16,
  localparam int LANE_BITS  = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic [31:0]           inbound_instruction_i,
  input  logic                  inbound_valid_i,
  output logic                  stall_o,
  input  logic [LANE_BITS-1:0]  mem_addr_lo_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  write_o,
  output logic [3:0]            write_index_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic [31:0]           outbound_instruction_o,
  output logic                  outbound_valid_o,
  input  logic                  halting_i,
  output logic                  halted_o,
  output logic                  bus_error_o
);

  localparam logic [4:0] OPCODE_NOP   = 5'h00;
  localparam logic [4:0] OPCODE_LOAD  = 5'h01;
  localparam logic [4:0] OPCODE_LOADI = 5'h02;

  localparam logic [1:0] CW_BYTE = 2'd0;
  localparam logic [1:0] CW_WORD = 2'd1;
  localparam logic [1:0] CW_LONG = 2'd2;

  localparam logic [1:0] IT_UNSIGNED = 2'd0;
  localparam logic [1:0] IT_SIGNED   = 2'd1;
  localparam logic [1:0] IT_TOP      = 2'd2;

  localparam int NUM_BYTES  = DATA_WIDTH / 8;
  localparam int NUM_HALVES = DATA_WIDTH / 16;

  // Last counter value before a timeout fires; mem_valid on that edge still wins.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [3:0]            write_index_q, write_index_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  halted_q, halted_d;
  logic                  bus_error_q, bus_error_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic [31:0]           ld_instr_q, ld_instr_d;
  logic [LANE_BITS-1:0]  ld_addr_q, ld_addr_d;
  logic                  halt_pend_q, halt_pend_d;

  // Memory word split into byte and half-word lanes.
  logic [7:0]  byte_lane [NUM_BYTES];
  logic [15:0] half_lane [NUM_HALVES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_lane
      assign byte_lane[gi] = data_in_i[gi*8 +: 8];
    end
    for (gi = 0; gi < NUM_HALVES; gi++) begin : g_half_lane
      assign half_lane[gi] = data_in_i[gi*16 +: 16];
    end
  endgenerate

  // The LOAD being served: the latched one while waiting, else the inbound one.
  logic [31:0]          ld_instr;
  logic [LANE_BITS-1:0] ld_addr;
  assign ld_instr = (state_q == ST_WAIT_MEM) ? ld_instr_q : inbound_instruction_i;
  assign ld_addr  = (state_q == ST_WAIT_MEM) ? ld_addr_q  : mem_addr_lo_i;

  logic [DATA_WIDTH-1:0]        ld_raw;
  logic signed [DATA_WIDTH-1:0] ld_shl;
  int                           ld_shift;
  logic [DATA_WIDTH-1:0]        load_value;

  // Select the addressed lane, then extend: shift the field to the top and
  // shift back arithmetically when the signed bit is set.
  always_comb begin
    ld_raw   = '0;
    ld_shift = 0;
    case (ld_instr[26:25])
      CW_BYTE: begin
        ld_raw   = DATA_WIDTH'(byte_lane[ld_addr]);
        ld_shift = DATA_WIDTH - 8;
      end
      CW_WORD: begin
        ld_raw   = DATA_WIDTH'(half_lane[ld_addr[LANE_BITS-1:1]]);
        ld_shift = DATA_WIDTH - 16;
      end
      CW_LONG: begin
        ld_raw   = DATA_WIDTH'(data_in_i[31:0]);
        ld_shift = DATA_WIDTH - 32;
      end
      default: begin
        ld_raw   = data_in_i;
        ld_shift = 0;
      end
    endcase
    ld_shl = $signed(ld_raw << ld_shift);
    if (ld_instr[24]) begin
      load_value = ld_shl >>> ld_shift;
    end else begin
      load_value = ld_raw;
    end
  end

  logic [15:0]           imm;
  logic [DATA_WIDTH-1:0] loadi_value;
  assign imm = inbound_instruction_i[15:0];

  // LOADI immediate expansion.
  always_comb begin
    case (inbound_instruction_i[26:25])
      IT_UNSIGNED: loadi_value = DATA_WIDTH'(imm);
      IT_SIGNED:   loadi_value = {{(DATA_WIDTH-16){imm[15]}}, imm};
      IT_TOP:      loadi_value = DATA_WIDTH'({imm, 16'h0000});
      default:     loadi_value = (read_data_i & ~DATA_WIDTH'(16'hFFFF)) | DATA_WIDTH'(imm);
    endcase
  end

  // Next-state and retirement decisions.
  always_comb begin
    state_d       = state_q;
    write_d       = 1'b0;
    write_index_d = write_index_q;
    write_data_d  = write_data_q;
    out_instr_d   = out_instr_q;
    out_valid_d   = 1'b0;
    bus_error_d   = bus_error_q;
    wait_cnt_d    = wait_cnt_q;
    ld_instr_d    = ld_instr_q;
    ld_addr_d     = ld_addr_q;
    halt_pend_d   = halt_pend_q;
    stall_o       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (inbound_valid_i) begin
          if (inbound_instruction_i[31:27] == OPCODE_LOADI) begin
            write_d       = 1'b1;
            write_index_d = inbound_instruction_i[23:20];
            write_data_d  = loadi_value;
            out_instr_d   = inbound_instruction_i;
            out_valid_d   = 1'b1;
            if (halting_i) state_d = ST_HALT;
          end else if (inbound_instruction_i[31:27] == OPCODE_LOAD) begin
            if (mem_valid_i) begin
              write_d       = 1'b1;
              write_index_d = ld_instr[23:20];
              write_data_d  = load_value;
              out_instr_d   = ld_instr;
              out_valid_d   = 1'b1;
              if (halting_i) state_d = ST_HALT;
            end else begin
              stall_o     = 1'b1;
              state_d     = ST_WAIT_MEM;
              ld_instr_d  = inbound_instruction_i;
              ld_addr_d   = mem_addr_lo_i;
              wait_cnt_d  = 8'd0;
              halt_pend_d = halting_i;
            end
          end else begin
            out_instr_d = inbound_instruction_i;
            out_valid_d = 1'b1;
            if (halting_i) state_d = ST_HALT;
          end
        end
      end
      ST_WAIT_MEM: begin
        stall_o = 1'b1;
        if (mem_valid_i) begin
          write_d       = 1'b1;
          write_index_d = ld_instr[23:20];
          write_data_d  = load_value;
          out_instr_d   = ld_instr;
          out_valid_d   = 1'b1;
          state_d       = halt_pend_q ? ST_HALT : ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          bus_error_d = 1'b1;
          state_d     = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_HALT: begin
        stall_o = 1'b1;
      end
      default: begin
        stall_o = 1'b1;
        state_d = ST_HALT;
      end
    endcase

    halted_d = (state_d == ST_HALT);
  end

  // State and output registers; reset returns everything to an idle NOP.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= ST_RUN;
      write_q       <= 1'b0;
      write_index_q <= 4'd0;
      write_data_q  <= '0;
      out_instr_q   <= {OPCODE_NOP, 27'h0};
      out_valid_q   <= 1'b0;
      halted_q      <= 1'b0;
      bus_error_q   <= 1'b0;
      wait_cnt_q    <= 8'd0;
      ld_instr_q    <= 32'h0;
      ld_addr_q     <= '0;
      halt_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      write_index_q <= write_index_d;
      write_data_q  <= write_data_d;
      out_instr_q   <= out_instr_d;
      out_valid_q   <= out_valid_d;
      halted_q      <= halted_d;
      bus_error_q   <= bus_error_d;
      wait_cnt_q    <= wait_cnt_d;
      ld_instr_q    <= ld_instr_d;
      ld_addr_q     <= ld_addr_d;
      halt_pend_q   <= halt_pend_d;
    end
  end

  assign write_o                = write_q;
  assign write_index_o          = write_index_q;
  assign write_data_o           = write_data_q;
  assign outbound_instruction_o = out_instr_q;
  assign outbound_valid_o       = out_valid_q;
  assign halted_o               = halted_q;
  assign bus_error_o            = bus_error_q;

endmodule
